// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 exception handler.
// Holds CP0 register numbers, decoder exception codes, Cause.ExcCode field
// values, the exception vector and Status/Cause bit positions and write masks.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Exception codes produced by the M-stage decoder
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] EXC_NONE = 32'hffff_ffff;

  // Cause.ExcCode field values
  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Status bit positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_IM_HI = 15;
  localparam int unsigned STATUS_BEV   = 22;

  // Cause bit positions
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_SW_LO  = 8;
  localparam int unsigned CAUSE_SW_HI  = 9;
  localparam int unsigned CAUSE_HW_LO  = 10;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD     = 31;

  // Software-writable bits of Status (IM, EXL, IE)
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  // Map a decoder code onto the Cause.ExcCode field (interrupts record 0)
  function automatic logic [4:0] exc_code_field(input logic [31:0] code);
    return (code == EXC_INT) ? EXCCODE_INT : code[4:0];
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for CP0.
// Count advances every second cycle via a toggle; timer_flag latches one cycle
// after Count==Compare and is cleared only by a Compare write.
// Ports: clk, rst (sync, active-high), count_we/compare_we (mtc0 strobes),
//        wdata (mtc0 data), count, compare, timer_flag (registered state).
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_flag
);

  logic toggle;

  // Count/toggle: a Count write reloads and restarts the half-rate phase
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      toggle <= 1'b0;
    end else if (count_we) begin
      count  <= wdata;
      toggle <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (toggle) count <= count + 32'd1;
    end
  end

  // Compare/flag: Compare write clears the flag even on a same-cycle match
  always_ff @(posedge clk) begin
    if (rst) begin
      compare    <= '0;
      timer_flag <= 1'b0;
    end else if (compare_we) begin
      compare    <= wdata;
      timer_flag <= 1'b0;
    end else if (count == compare) begin
      timer_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_except_handler.sv
// cp0_except_handler: CP0 exception sink for the MIPS pipeline.
// Commits Status/Cause/EPC/BadVAddr on M-stage exceptions, redirects fetch to
// the exception vector (or EPC on eret), services mtc0/mfc0 and raises the
// pending-interrupt flag. Optional Count/Compare timer under CP0_TIMER_EN.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exceptionTypeM, pcM, badAddrM, isInDelaySlotM   M-stage exception info
//   intHw[5:0]                    level-sensitive hardware interrupts
//   weM, waddrM, wdataM           mtc0 write port
//   raddr, rdata                  mfc0 read port (combinational)
//   flushExcept, newPc            same-cycle redirect
//   interruptPending              to the decoder interrupt input
//   statusOut, causeOut, epcOut   register values for the pipeline
module cp0_except_handler #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exceptionTypeM,
  input  logic [31:0] pcM,
  input  logic [31:0] badAddrM,
  input  logic        isInDelaySlotM,
  input  logic [5:0]  intHw,
  input  logic        weM,
  input  logic [4:0]  waddrM,
  input  logic [31:0] wdataM,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic        flushExcept,
  output logic [31:0] newPc,
  output logic        interruptPending,
  output logic [31:0] statusOut,
  output logic [31:0] causeOut,
  output logic [31:0] epcOut
);

  import cp0_pkg::*;

  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_flag;

  logic is_eret;
  logic exc_commit;
  logic mtc0_ok;
  logic bad_addr_exc;

  assign is_eret      = (exceptionTypeM == EXC_ERET);
  assign flushExcept  = (exceptionTypeM != EXC_NONE);
  assign exc_commit   = flushExcept && !is_eret;
  // Any redirect in the same cycle drops the mtc0 entirely
  assign mtc0_ok      = weM && !flushExcept;
  assign bad_addr_exc = (exceptionTypeM == EXC_ADEL) || (exceptionTypeM == EXC_ADES);

  assign newPc = is_eret ? epc : EXC_VECTOR;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_ok && (waddrM == CP0_COUNT)),
    .compare_we (mtc0_ok && (waddrM == CP0_COMPARE)),
    .wdata      (wdataM),
    .count      (count),
    .compare    (compare),
    .timer_flag (timer_flag)
  );
`else
  assign count      = '0;
  assign compare    = '0;
  assign timer_flag = 1'b0;
`endif

  // Architectural register updates: exception > eret > mtc0
  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RESET;
      cause    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      if (exc_commit) begin
        status[STATUS_EXL] <= 1'b1;
        cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc_code_field(exceptionTypeM);
        // Nested exceptions keep the original return point
        if (!status[STATUS_EXL]) begin
          epc             <= isInDelaySlotM ? (pcM - 32'd4) : pcM;
          cause[CAUSE_BD] <= isInDelaySlotM;
        end
        if (bad_addr_exc) badvaddr <= badAddrM;
      end else if (is_eret) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (mtc0_ok) begin
        case (waddrM)
          CP0_STATUS: status <= (status & ~STATUS_WMASK) | (wdataM & STATUS_WMASK);
          CP0_CAUSE:  cause[CAUSE_SW_HI:CAUSE_SW_LO] <= wdataM[CAUSE_SW_HI:CAUSE_SW_LO];
          CP0_EPC:    epc <= wdataM;
          default:    ;
        endcase
      end
      // Hardware IP bits track the lines every cycle; timer shares IP7
      cause[CAUSE_IP_HI:CAUSE_HW_LO] <= {intHw[5] | timer_flag, intHw[4:0]};
    end
  end

  // mfc0 read mux
  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = epc;
      default:      rdata = '0;
    endcase
  end

  assign interruptPending = status[STATUS_IE] & ~status[STATUS_EXL] &
                            (|(cause[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]));

  assign statusOut = status;
  assign causeOut  = cause;
  assign epcOut    = epc;

endmodule
